hack_inst_encoder: RTL

- Writer-side counterpart of the Hack instruction decoder.
- Accepts field-level instruction beats over a valid/ready stream: either an A-instruction value, or C-instruction comp/dest/jump fields.
- Packs each beat into a 16-bit Hack word and writes it sequentially into instruction ROM.
- Holds the CPU in reset until the program load completes.

---
 rtl/hack_inst_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hack_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : hack_inst_encoder
// Brief    : Packs field-level Hack A/C instruction beats into 16-bit words,
//            writes them sequentially into instruction ROM and holds the CPU
//            in reset until the program load completes.
//            Optional macro HACK_ENC_CHECKSUM_EN enables the running checksum.
// Revision : 1.0 - initial release
// ============================================================================
module hack_inst_encoder #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_a,
    input  logic [14:0]       in_value,
    input  logic [6:0]        in_comp,
    input  logic [2:0]        in_dest,
    input  logic [2:0]        in_jump,
    input  logic              in_last,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   count,
    output logic [15:0]       checksum,
    output logic              cpu_rst_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    state_t             r_state;
    logic [ADDR_W:0]    r_count;
    logic               r_rom_we;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [15:0]        r_rom_wdata;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               r_cpu_rst_n;
    logic [15:0]        r_checksum;

    logic               w_accept;
    logic               w_full;
    logic [15:0]        w_word;

    assign in_ready = (r_state == S_LOAD) && !start;
    assign w_accept = in_valid && in_ready;
    // In LOAD the count never exceeds the last address, so the low bits suffice.
    assign w_full   = (r_count[ADDR_W-1:0] == c_last_addr);
    assign w_word   = in_is_a ? {1'b0, in_value}
                              : {3'b111, in_comp, in_dest, in_jump};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rom_we    <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_wdata <= 16'h0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_checksum  <= 16'h0000;
        end else begin
            r_rom_we <= 1'b0;
            if (start) begin
                r_state     <= S_LOAD;
                r_count     <= '0;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_error     <= 1'b0;
                r_cpu_rst_n <= 1'b0;
                r_checksum  <= 16'h0000;
            end else if (w_accept) begin
                r_rom_we    <= 1'b1;
                r_rom_addr  <= r_count[ADDR_W-1:0];
                r_rom_wdata <= w_word;
                r_count     <= r_count + (ADDR_W+1)'(1);
`ifdef HACK_ENC_CHECKSUM_EN
                r_checksum  <= r_checksum + w_word;
`endif
                if (in_last) begin
                    r_state     <= S_DONE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_cpu_rst_n <= 1'b1;
                end else if (w_full) begin
                    r_state <= S_ERR;
                    r_busy  <= 1'b0;
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign rom_we    = r_rom_we;
    assign rom_addr  = r_rom_addr;
    assign rom_wdata = r_rom_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign count     = r_count;
    assign cpu_rst_n = r_cpu_rst_n;
`ifdef HACK_ENC_CHECKSUM_EN
    assign checksum  = r_checksum;
`else
    assign checksum  = 16'h0000;
`endif

endmodule
`default_nettype wire
